vga_fetch: RTL and testbench

Read-only bus master that streams a frame buffer from the memory bus into a small show-ahead FIFO for the VGA pixel pipeline. It sits directly upstream of the bus controller on the VGA master port: it drives `vga_address`/`vga_read`, obeys `vga_wait`, and captures the shared read data bus. Downstream, the scan-out logic pops one 32-bit word per 4 pixels. All logic is clocked by a single clock.

---
 rtl/vga_fetch.sv | 172 +++++++++++++++++
 tb/tb_vga_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch.sv
// ---------------------------------------------------------------------------
// vga_fetch
//
// Read-only bus master that streams a frame buffer into a small show-ahead
// FIFO feeding the VGA scan-out pipeline. One request is outstanding at most;
// each accepted word is followed by a single idle cycle on vga_read so the
// bus controller can return to idle between transfers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request; issue when enabled, frame not done, FIFO not full
// REQ     | vga_read high, address held, waiting for vga_wait low
// RELEASE | one-cycle gap with vga_read low, then re-issue or go idle
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   base_addr             frame byte address, sampled on frame_start
//   enable                allows new requests (never aborts one in flight)
//   frame_start           one-cycle pulse: flush FIFO, restart the frame
//   vga_address/vga_read  bus request
//   vga_wait, readdata    bus wait and shared read data
//   pop                   consume FIFO head
//   pixel_data, empty     FIFO head word (0 when empty), empty flag
//   level                 FIFO occupancy
//   done                  whole frame fetched
//   underflow             sticky pop-while-empty flag
// ---------------------------------------------------------------------------
module vga_fetch #(
    parameter int DEPTH      = 16,
    parameter int LINE_WORDS = 160,
    parameter int LINES      = 480
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [31:0]              base_addr,
    input  logic                     enable,
    input  logic                     frame_start,
    output logic [31:0]              vga_address,
    output logic                     vga_read,
    input  logic                     vga_wait,
    input  logic [31:0]              readdata,
    input  logic                     pop,
    output logic [31:0]              pixel_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done,
    output logic                     underflow
);
    localparam int TOTAL = LINE_WORDS * LINES;
    localparam int PTR_W = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      base_q;
    logic [31:0]      addr_q;
    logic             read_q;
    logic [PTR_W-1:0] ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [LW-1:0]    level_q;
    logic             done_q;
    logic             underflow_q;
    logic [31:0]      mem_q [DEPTH];

    logic             push;
    logic             pop_ok;
    logic             can_issue;
    logic [PTR_W-1:0] ptr_d;
    logic [LW-1:0]    level_d;
    logic             done_d;
    logic [31:0]      next_addr;

    // A word returned in the same cycle as frame_start belongs to the old
    // frame and is dropped.
    assign push   = (state_q == REQ) && !vga_wait && !frame_start;
    assign pop_ok = pop && (level_q != '0) && !frame_start;

    // Requests are only issued with room in the FIFO, so a push can never
    // land on a full FIFO even if no pop arrives while the request is open.
    assign can_issue = enable && !done_q && (level_q < LW'(DEPTH));
    assign next_addr = base_q + (32'(ptr_q) << 2);

    assign ptr_d   = push ? ptr_q + 1'b1 : ptr_q;
    assign done_d  = done_q | (push && (ptr_q == PTR_W'(TOTAL - 1)));
    assign level_d = level_q + LW'(push) - LW'(pop_ok);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            ptr_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else if (frame_start) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            base_q      <= base_addr & 32'hFFFF_FFFC;
            ptr_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop && (level_q == '0)) begin
                underflow_q <= 1'b1;
            end

            case (state_q)
                IDLE, RELEASE: begin
                    // In RELEASE, ptr_q/level_q already include the word
                    // captured on the previous edge.
                    if (can_issue) begin
                        state_q <= REQ;
                        read_q  <= 1'b1;
                        addr_q  <= next_addr;
                    end else begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                    end
                end
                REQ: begin
                    if (!vga_wait) begin
                        state_q <= RELEASE;
                        read_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= readdata;
        end
    end

    assign vga_address = addr_q;
    assign vga_read    = read_q;
    assign empty       = (level_q == '0);
    assign pixel_data  = (level_q == '0) ? 32'h0 : mem_q[rd_ptr_q];
    assign level       = level_q;
    assign done        = done_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fetch.sv
module tb_vga_fetch;
    localparam int BUS_LAT   = 5;
    localparam int BUS_LAT_B = 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // main instance: DEPTH 16, full-size frame
    logic        reset_n;
    logic [31:0] base_addr;
    logic        enable, frame_start, pop;
    logic [31:0] vga_address, readdata, pixel_data;
    logic        vga_read, vga_wait, empty, done, underflow;
    logic [4:0]  level;

    // small-frame instance: 4 words x 2 lines
    logic [31:0] base_b;
    logic        enable_b, frame_start_b, pop_b;
    logic [31:0] vga_address_b, readdata_b, pixel_data_b;
    logic        vga_read_b, vga_wait_b, empty_b, done_b, underflow_b;
    logic [4:0]  level_b;

    vga_fetch #(.DEPTH(16), .LINE_WORDS(160), .LINES(480)) dut (
        .clock(clock), .reset_n(reset_n), .base_addr(base_addr), .enable(enable),
        .frame_start(frame_start), .vga_address(vga_address), .vga_read(vga_read),
        .vga_wait(vga_wait), .readdata(readdata), .pop(pop), .pixel_data(pixel_data),
        .empty(empty), .level(level), .done(done), .underflow(underflow)
    );

    vga_fetch #(.DEPTH(16), .LINE_WORDS(4), .LINES(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .base_addr(base_b), .enable(enable_b),
        .frame_start(frame_start_b), .vga_address(vga_address_b), .vga_read(vga_read_b),
        .vga_wait(vga_wait_b), .readdata(readdata_b), .pop(pop_b), .pixel_data(pixel_data_b),
        .empty(empty_b), .level(level_b), .done(done_b), .underflow(underflow_b)
    );

    // bus models: wait drops BUS_LAT cycles after vga_read rises, data = address
    int rd_cnt = 0, rd_cnt_b = 0;
    always @(posedge clock) rd_cnt   <= vga_read   ? rd_cnt + 1   : 0;
    always @(posedge clock) rd_cnt_b <= vga_read_b ? rd_cnt_b + 1 : 0;
    assign vga_wait   = !(vga_read   && (rd_cnt   >= BUS_LAT));
    assign vga_wait_b = !(vga_read_b && (rd_cnt_b >= BUS_LAT_B));
    assign readdata   = vga_read   ? vga_address   : 32'hDEAD_BEEF;
    assign readdata_b = vga_read_b ? vga_address_b : 32'hDEAD_BEEF;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard for the main instance
    logic [31:0] sb_q[$];
    logic [31:0] addr_log[$];
    int          req_cyc[$];
    int          low_q[$];
    logic [31:0] base_m = 0;
    int          ptr_m = 0, n_req = 0, n_cap = 0, last_fall = 0;
    logic [31:0] last_addr = 0;
    bit          rd_prev = 0;

    always @(negedge clock) begin : mon_a
        bit had;
        if (!reset_n) begin
            sb_q.delete();
            ptr_m   = 0;
            base_m  = 0;
            rd_prev = 0;
        end else begin
            check("level_vs_model", 32'(level), 32'(sb_q.size()));
            if (vga_read && !rd_prev) begin
                n_req++;
                req_cyc.push_back(cyc);
                low_q.push_back(cyc - last_fall);
                addr_log.push_back(vga_address);
                last_addr = vga_address;
                check("req_addr", vga_address, base_m + 32'(ptr_m * 4));
            end
            if (!vga_read && rd_prev) last_fall = cyc;
            if (frame_start) begin
                sb_q.delete();
                ptr_m  = 0;
                base_m = base_addr & 32'hFFFF_FFFC;
            end else begin
                had = (sb_q.size() > 0);
                if (pop) check("pixel_data", pixel_data, had ? sb_q[0] : 32'h0);
                if (vga_read && !vga_wait) begin
                    sb_q.push_back(readdata);
                    ptr_m++;
                    n_cap++;
                end
                if (pop && had) void'(sb_q.pop_front());
            end
            rd_prev = vga_read;
        end
    end

    // request tracking for the small-frame instance
    logic [31:0] base_bm = 0, last_addr_b = 0;
    int          ptr_bm = 0, n_req_b = 0;
    bit          rd_prev_b = 0;

    always @(negedge clock) begin : mon_b
        if (!reset_n) begin
            ptr_bm = 0; base_bm = 0; rd_prev_b = 0;
        end else begin
            if (vga_read_b && !rd_prev_b) begin
                n_req_b++;
                last_addr_b = vga_address_b;
                check("b_req_addr", vga_address_b, base_bm + 32'(ptr_bm * 4));
            end
            if (frame_start_b) begin
                ptr_bm = 0;
                base_bm = base_b & 32'hFFFF_FFFC;
            end else if (vga_read_b && !vga_wait_b) begin
                check("b_done_early", 32'(done_b), 32'd0);
                ptr_bm++;
            end
            rd_prev_b = vga_read_b;
        end
    end

    typedef struct {
        bit en;
        int pops;
        int idle;
        int exp_level;
        int exp_new;
        bit exp_uf;
    } step_t;
    step_t steps[5];

    int t, r0, c0, idx, fs_cyc;
    logic [31:0] a0;

    initial begin
        steps[0] = '{en: 1'b0, pops: 3,  idle: 20,  exp_level: 13, exp_new: 0,  exp_uf: 1'b0};
        steps[1] = '{en: 1'b0, pops: 13, idle: 20,  exp_level: 0,  exp_new: 0,  exp_uf: 1'b0};
        steps[2] = '{en: 1'b0, pops: 1,  idle: 5,   exp_level: 0,  exp_new: 0,  exp_uf: 1'b1};
        steps[3] = '{en: 1'b1, pops: 0,  idle: 200, exp_level: 16, exp_new: 16, exp_uf: 1'b1};
        steps[4] = '{en: 1'b1, pops: 4,  idle: 60,  exp_level: 16, exp_new: 4,  exp_uf: 1'b1};

        reset_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pop = 1'b0;
        base_addr = 32'h1234_5678;
        enable_b = 1'b0; frame_start_b = 1'b0; pop_b = 1'b0; base_b = 32'h0;

        // ---- reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_vga_read", 32'(vga_read), 32'd0);
        check("rst_vga_address", vga_address, 32'h0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_pixel_data", pixel_data, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // ---- first requests: address, latency, spacing
        @(posedge clock); #1;
        reset_n = 1'b1; base_addr = 32'h00C0_0000; enable = 1'b1; frame_start = 1'b1;
        fs_cyc = cyc;
        @(posedge clock); #1;
        frame_start = 1'b0;
        t = 0;
        while (n_req < 3 && t < 100) begin @(negedge clock); t++; end
        check("start_timeout", 32'(t < 100), 32'd1);
        check("first_latency", 32'(req_cyc[0] - fs_cyc), 32'd2);
        check("addr0", addr_log[0], 32'h00C0_0000);
        check("addr1", addr_log[1], 32'h00C0_0004);
        check("spacing01", 32'(req_cyc[1] - req_cyc[0]), 32'd7);
        check("spacing12", 32'(req_cyc[2] - req_cyc[1]), 32'd7);
        check("low_gap", 32'(low_q[1]), 32'd1);

        // ---- fill to DEPTH with no pops
        t = 0;
        while (level != 5'd16 && t < 300) begin @(negedge clock); t++; end
        check("fill_timeout", 32'(t < 300), 32'd1);
        repeat (40) @(negedge clock);
        check("fill_nreq", 32'(n_req), 32'd16);
        check("fill_level", 32'(level), 32'd16);
        check("fill_read_low", 32'(vga_read), 32'd0);
        check("fill_empty", 32'(empty), 32'd0);

        @(posedge clock); #1; pop = 1'b1;
        @(posedge clock); #1; pop = 1'b0;
        repeat (30) @(posedge clock);
        @(negedge clock);
        check("refill_nreq", 32'(n_req), 32'd17);
        check("refill_addr", addr_log[16], 32'h00C0_0040);
        check("refill_level", 32'(level), 32'd16);

        // ---- drain / enable / underflow table
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            r0 = n_req;
            enable = steps[i].en;
            for (int p = 0; p < steps[i].pops; p++) begin
                pop = 1'b1;
                @(posedge clock); #1;
            end
            pop = 1'b0;
            repeat (steps[i].idle) @(posedge clock);
            @(negedge clock);
            check($sformatf("step%0d_level", i), 32'(level), 32'(steps[i].exp_level));
            check($sformatf("step%0d_newreq", i), 32'(n_req - r0), 32'(steps[i].exp_new));
            check($sformatf("step%0d_underflow", i), 32'(underflow), 32'(steps[i].exp_uf));
            @(posedge clock); #1;
        end

        // ---- frame_start in the capture cycle of a request
        pop = 1'b1;
        @(posedge clock); #1; pop = 1'b0;
        t = 0;
        while (!(vga_read && rd_cnt == BUS_LAT - 1) && t < 30) begin @(negedge clock); t++; end
        check("fs_wait_timeout", 32'(t < 30), 32'd1);
        @(posedge clock); #1;
        frame_start = 1'b1; base_addr = 32'hFFFF_FFFB;
        @(negedge clock);
        check("fs_in_capture", 32'(vga_wait), 32'd0);
        @(posedge clock); #1; frame_start = 1'b0;
        idx = addr_log.size();
        r0  = n_req;
        @(negedge clock);
        check("fs_read_low", 32'(vga_read), 32'd0);
        check("fs_level", 32'(level), 32'd0);
        check("fs_underflow_clr", 32'(underflow), 32'd0);
        t = 0;
        while (n_req < r0 + 3 && t < 60) begin @(negedge clock); t++; end
        check("fs_req_timeout", 32'(t < 60), 32'd1);
        check("wrap_addr0", addr_log[idx], 32'hFFFF_FFF8);
        check("wrap_addr1", addr_log[idx+1], 32'hFFFF_FFFC);
        check("wrap_addr2", addr_log[idx+2], 32'h0000_0000);

        // ---- pop in the capture cycle with level 5
        t = 0;
        while (!(level == 5'd5 && vga_read && rd_cnt == BUS_LAT - 1) && t < 100) begin
            @(negedge clock); t++;
        end
        check("pp_timeout", 32'(t < 100), 32'd1);
        @(posedge clock); #1; pop = 1'b1;
        @(negedge clock);
        check("pp_capture", 32'(vga_wait), 32'd0);
        @(posedge clock); #1; pop = 1'b0; enable = 1'b0;
        @(negedge clock);
        check("pp_level", 32'(level), 32'd5);
        @(posedge clock); #1;
        repeat (5) begin pop = 1'b1; @(posedge clock); #1; end
        pop = 1'b0;
        @(negedge clock);
        check("pp_drained", 32'(empty), 32'd1);

        // ---- enable dropped while a request waits
        @(posedge clock); #1; enable = 1'b1;
        t = 0;
        while (!(vga_read && rd_cnt == 1) && t < 20) begin @(negedge clock); t++; end
        check("gate_timeout", 32'(t < 20), 32'd1);
        @(posedge clock); #1; enable = 1'b0;
        a0 = last_addr; c0 = n_cap; r0 = n_req;
        repeat (40) @(negedge clock);
        check("gate_captured", 32'(n_cap - c0), 32'd1);
        check("gate_noreq", 32'(n_req - r0), 32'd0);
        check("gate_read_low", 32'(vga_read), 32'd0);
        check("gate_level", 32'(level), 32'd1);
        @(posedge clock); #1; enable = 1'b1;
        t = 0;
        while (n_req == r0 && t < 20) begin @(negedge clock); t++; end
        check("resume_timeout", 32'(t < 20), 32'd1);
        check("resume_addr", last_addr, a0 + 32'd4);

        // ---- end of frame on the small instance
        @(posedge clock); #1;
        base_b = 32'h0000_2000; enable_b = 1'b1; frame_start_b = 1'b1;
        @(posedge clock); #1; frame_start_b = 1'b0;
        t = 0;
        while (!done_b && t < 200) begin @(negedge clock); t++; end
        check("b_done_timeout", 32'(t < 200), 32'd1);
        check("b_nreq", 32'(n_req_b), 32'd8);
        check("b_level", 32'(level_b), 32'd8);
        check("b_last_addr", last_addr_b, 32'h0000_201C);
        repeat (30) @(negedge clock);
        check("b_nreq_after", 32'(n_req_b), 32'd8);
        check("b_read_low", 32'(vga_read_b), 32'd0);
        check("b_done_held", 32'(done_b), 32'd1);
        @(posedge clock); #1; enable_b = 1'b0; frame_start_b = 1'b1;
        @(posedge clock); #1; frame_start_b = 1'b0;
        @(negedge clock);
        check("b_done_clr", 32'(done_b), 32'd0);
        check("b_level_clr", 32'(level_b), 32'd0);

        // ---- reset in the middle of a request
        @(posedge clock); #1;
        t = 0;
        while (!(vga_read && rd_cnt == 1) && t < 20) begin @(negedge clock); t++; end
        check("mid_rst_timeout", 32'(t < 20), 32'd1);
        @(posedge clock); #1; reset_n = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1; enable = 1'b0;
        @(negedge clock);
        check("mid_rst_read", 32'(vga_read), 32'd0);
        check("mid_rst_addr", vga_address, 32'h0);
        check("mid_rst_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
